formatter: RTL and testbench

FORMATTER -- requirements
Module: formatter

---
 rtl/mcdf_pkg.sv | 36 +++
 rtl/fmt_buf.sv | 33 +++
 rtl/formatter.sv | 137 +++++++++++++
 tb/tb_formatter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcdf_pkg.sv
// Shared types for the formatter: FSM state, packet header, length codes and decode.
package mcdf_pkg;

    localparam int DATA_W    = 32;
    localparam int BUF_DEPTH = 32;
    localparam int ADDR_W    = 5;

    localparam logic [5:0] LEN4  = 6'd4;
    localparam logic [5:0] LEN8  = 6'd8;
    localparam logic [5:0] LEN16 = 6'd16;
    localparam logic [5:0] LEN32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        COLLECT,
        SEND_REQ,
        SEND
    } fmt_state_t;

    typedef struct packed {
        logic [1:0] chid;
        logic [5:0] length;
    } fmt_hdr_t;

    // Codes 4..7 are reserved and saturate to the largest packet.
    function automatic logic [5:0] pkglen_decode(input logic [2:0] sel);
        case (sel)
            3'd0:    return LEN4;
            3'd1:    return LEN8;
            3'd2:    return LEN16;
            default: return LEN32;
        endcase
    endfunction

endpackage

// File: rtl/fmt_buf.sv
// Purpose: 32x32 packet word store, one synchronous write port, one read port.
// Latency: read data appears the cycle after rd_en; write visible the cycle after wr_en.
// Backpressure: none; the formatter FSM owns all sequencing.
module fmt_buf
    import mcdf_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            rd_dat <= '0;
        end else if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/formatter.sv
// Purpose: collect one packet from the arbiter, then send it downstream framed with start/end; FMT_PARITY_EN adds fmt_parity_o.
// Latency: first word one cycle after grant, then one word per cycle; 2-cycle gap between packets.
// Backpressure: arbiter words acked combinationally only while collecting; downstream holds off via fmt_grant_i.
module formatter
    import mcdf_pkg::*;
(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              a2f_val_i,
    input  logic [1:0]        a2f_id_i,
    input  logic [DATA_W-1:0] a2f_data_i,
    input  logic [2:0]        a2f_pkglen_sel_i,
    output logic              f2a_id_req_o,
    output logic              f2a_ack_o,
    output logic              fmt_req_o,
    input  logic              fmt_grant_i,
    output logic [1:0]        fmt_chid_o,
    output logic [5:0]        fmt_length_o,
    output logic [DATA_W-1:0] fmt_data_o,
    output logic              fmt_start_o,
`ifdef FMT_PARITY_EN
    output logic              fmt_parity_o,
`endif
    output logic              fmt_end_o
);

    fmt_state_t        state, state_nxt;
    fmt_hdr_t          hdr_q;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] send_idx;
    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0] rd_dat;
    logic              last_wr, last_send, in_send;

    assign last_wr   = ({1'b0, wr_cnt} == (hdr_q.length - 6'd1));
    assign last_send = ({1'b0, send_idx} == (hdr_q.length - 6'd1));
    assign in_send   = (state == SEND);

    always_comb begin
        state_nxt    = state;
        f2a_id_req_o = 1'b0;
        f2a_ack_o    = 1'b0;
        fmt_req_o    = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = wr_cnt;
        rd_en        = 1'b0;
        rd_addr      = send_idx + 5'd1;
        case (state)
            IDLE: state_nxt = ID_REQ;
            ID_REQ: begin
                f2a_id_req_o = 1'b1;
                if (a2f_val_i) begin
                    f2a_ack_o = 1'b1;
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                f2a_ack_o = a2f_val_i;
                if (a2f_val_i) begin
                    wr_en = 1'b1;
                    if (last_wr) begin
                        state_nxt = SEND_REQ;
                    end
                end
            end
            SEND_REQ: begin
                fmt_req_o = 1'b1;
                // Prefetch word 0 so it is on the bus the cycle after grant.
                if (fmt_grant_i) begin
                    rd_en     = 1'b1;
                    rd_addr   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                rd_en = 1'b1;
                if (last_send) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            hdr_q    <= '0;
            wr_cnt   <= '0;
            send_idx <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ID_REQ: begin
                    if (a2f_val_i) begin
                        hdr_q.chid   <= a2f_id_i;
                        hdr_q.length <= pkglen_decode(a2f_pkglen_sel_i);
                        wr_cnt       <= 5'd1;
                    end
                end
                COLLECT: begin
                    if (a2f_val_i) begin
                        wr_cnt <= last_wr ? '0 : wr_cnt + 5'd1;
                    end
                end
                SEND_REQ: send_idx <= '0;
                SEND:     send_idx <= send_idx + 5'd1;
                default: ;
            endcase
        end
    end

    fmt_buf u_buf (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_dat  (a2f_data_i),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    assign fmt_chid_o   = hdr_q.chid;
    assign fmt_length_o = hdr_q.length;
    assign fmt_data_o   = in_send ? rd_dat : '0;
    assign fmt_start_o  = in_send && (send_idx == '0);
    assign fmt_end_o    = in_send && last_send;

`ifdef FMT_PARITY_EN
    assign fmt_parity_o = ^fmt_data_o;
`endif

endmodule

// File: tb/tb_formatter.sv
// Scoreboard bench for formatter: expected output words queued as arbiter words are driven.
module tb_formatter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        a2f_val_i;
    logic [1:0]  a2f_id_i;
    logic [31:0] a2f_data_i;
    logic [2:0]  a2f_pkglen_sel_i;
    logic        f2a_id_req_o;
    logic        f2a_ack_o;
    logic        fmt_req_o;
    logic        fmt_grant_i;
    logic [1:0]  fmt_chid_o;
    logic [5:0]  fmt_length_o;
    logic [31:0] fmt_data_o;
    logic        fmt_start_o;
    logic        fmt_end_o;
`ifdef FMT_PARITY_EN
    logic        fmt_parity_o;
`endif

    formatter dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .a2f_val_i        (a2f_val_i),
        .a2f_id_i         (a2f_id_i),
        .a2f_data_i       (a2f_data_i),
        .a2f_pkglen_sel_i (a2f_pkglen_sel_i),
        .f2a_id_req_o     (f2a_id_req_o),
        .f2a_ack_o        (f2a_ack_o),
        .fmt_req_o        (fmt_req_o),
        .fmt_grant_i      (fmt_grant_i),
        .fmt_chid_o       (fmt_chid_o),
        .fmt_length_o     (fmt_length_o),
        .fmt_data_o       (fmt_data_o),
        .fmt_start_o      (fmt_start_o),
`ifdef FMT_PARITY_EN
        .fmt_parity_o     (fmt_parity_o),
`endif
        .fmt_end_o        (fmt_end_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] dat;
        logic        start;
        logic        last;
        logic [1:0]  chid;
        logic [5:0]  len;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] wbuf [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        rx_active = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_len(input logic [2:0] sel);
        return (sel >= 3'd3) ? 32 : (4 << sel);
    endfunction

    // Output monitor: every presented word must match the head of the scoreboard.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rstn_i) begin
            rx_active = 1'b0;
        end else if (fmt_start_o || rx_active) begin
            check("word_expected", 64'(exp_q.size() > 0), 64'd1);
            e = '{dat: 32'h0, start: 1'b0, last: 1'b0, chid: 2'd0, len: 6'd0};
            if (exp_q.size() > 0) e = exp_q.pop_front();
            check("out_data",  fmt_data_o,   e.dat);
            check("out_start", fmt_start_o,  e.start);
            check("out_end",   fmt_end_o,    e.last);
            check("out_chid",  fmt_chid_o,   e.chid);
            check("out_len",   fmt_length_o, e.len);
`ifdef FMT_PARITY_EN
            check("out_parity", fmt_parity_o, ^e.dat);
`endif
            rx_active = !fmt_end_o;
        end else begin
            check("idle_data",  fmt_data_o, 32'h0);
            check("idle_flags", {fmt_start_o, fmt_end_o}, 2'b00);
`ifdef FMT_PARITY_EN
            check("idle_parity", fmt_parity_o, 1'b0);
`endif
        end
    end

    task automatic wait_id_req();
        int waited = 0;
        while (!f2a_id_req_o && waited < 50) begin
            @(negedge clk_i); #1;
            waited++;
        end
        check("id_req", f2a_id_req_o, 1'b1);
    endtask

    task automatic send_pkt(input logic [1:0] id, input logic [2:0] sel,
                            input int gap_every, input int hold);
        int n = exp_len(sel);
        int waited = 0;
        wait_id_req();
        for (int i = 0; i < n; i++) begin
            a2f_val_i  = 1'b1;
            a2f_data_i = wbuf[i];
            // Only the first word's id/sel may be captured.
            a2f_id_i         = (i == 0) ? id : ~id;
            a2f_pkglen_sel_i = (i == 0) ? sel : 3'(i);
            fmt_grant_i      = (gap_every != 0);
            exp_q.push_back('{dat: wbuf[i], start: (i == 0), last: (i == n - 1),
                              chid: id, len: 6'(n)});
            #1 check("ack", f2a_ack_o, 1'b1);
            @(negedge clk_i); #1;
            if (gap_every != 0 && (i % gap_every) == gap_every - 1 && i != n - 1) begin
                repeat (2) begin
                    a2f_val_i  = 1'b0;
                    a2f_data_i = $urandom;
                    #1 check("gap_ack", f2a_ack_o, 1'b0);
                    @(negedge clk_i); #1;
                end
            end
        end
        fmt_grant_i = 1'b0;
        a2f_val_i   = 1'b1;
        a2f_data_i  = 32'hDEAD_BEEF;
        for (int h = 0; h < hold; h++) begin
            #1 check("req_hold", fmt_req_o, 1'b1);
            check("ack_in_sendreq", f2a_ack_o, 1'b0);
            @(negedge clk_i); #1;
        end
        fmt_grant_i = 1'b1;
        #1 check("req_before_grant", fmt_req_o, 1'b1);
        check("ack_at_grant", f2a_ack_o, 1'b0);
        @(negedge clk_i); #1;
        fmt_grant_i = 1'b0;
        check("req_after_grant", fmt_req_o, 1'b0);
        check("start_after_grant", fmt_start_o, 1'b1);
        while (exp_q.size() != 0 && waited < 100) begin
            check("ack_in_send", f2a_ack_o, 1'b0);
            @(negedge clk_i); #1;
            waited++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk_i); #1;
        check("gap_idle_ack", f2a_ack_o, 1'b0);
        check("gap_idle", f2a_id_req_o, 1'b0);
        a2f_val_i = 1'b0;
        @(negedge clk_i); #1;
        check("gap_idreq", f2a_id_req_o, 1'b1);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({f2a_id_req_o, f2a_ack_o, fmt_req_o, fmt_chid_o, fmt_length_o,
                    fmt_data_o, fmt_start_o, fmt_end_o});
    endfunction

    initial begin
        rstn_i = 1'b0;
        a2f_val_i = 1'b0;
        a2f_id_i = 2'd0;
        a2f_data_i = 32'h0;
        a2f_pkglen_sel_i = 3'd0;
        fmt_grant_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 check("reset_outs", all_outs(), 64'h0);
        rstn_i = 1'b1;

        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        send_pkt(2'd2, 3'd0, 0, 0);

        for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
        send_pkt(2'd1, 3'd6, 0, 2);

        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
        send_pkt(2'd3, 3'd1, 3, 10);

        for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
        send_pkt(2'd0, 3'd2, 5, 1);

        // Abort a packet after 3 of 8 words.
        wait_id_req();
        a2f_pkglen_sel_i = 3'd1;
        a2f_id_i = 2'd1;
        for (int i = 0; i < 3; i++) begin
            a2f_val_i  = 1'b1;
            a2f_data_i = 32'hA000_0000 + 32'(i);
            #1 check("ack_pre_rst", f2a_ack_o, 1'b1);
            @(negedge clk_i); #1;
        end
        rstn_i = 1'b0;
        a2f_val_i = 1'b0;
        @(negedge clk_i); #1;
        check("rst_mid_outs", all_outs(), 64'h0);
        @(negedge clk_i); #1;
        check("rst_mid_outs2", all_outs(), 64'h0);
        rstn_i = 1'b1;
        @(negedge clk_i); #1;
        @(negedge clk_i); #1;
        check("id_req_after_rst", f2a_id_req_o, 1'b1);
        for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
        send_pkt(2'd2, 3'd3, 0, 0);

        wbuf[0] = 32'h0000_0007;
        wbuf[1] = 32'h0000_0003;
        wbuf[2] = 32'hFFFF_FFFF;
        wbuf[3] = 32'h8000_0001;
        send_pkt(2'd1, 3'd0, 0, 0);

        repeat (3) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
